// File: rtl/gray_conv_scheduler.sv
// Shared binary<->Gray converter with a two-requester round-robin front end.
// Define GRAY_CONV_STATS_EN to add the conv_count completion counter port.
module gray_conv_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result
`ifdef GRAY_CONV_STATS_EN
    ,
    output logic [7:0]       conv_count
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic             last_id;
    logic             cur_id;
    logic             cur_dir;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    bit_idx;
    logic             prev_bit;

    logic             any_req;
    logic             pick1;
    logic             g2b_bit;
    logic             conv_last;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] conv_value;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_req    = req0 | req1;
        // last_id == 1 means requester 1 was served last, so requester 0 wins a tie.
        pick1      = req1 & (~req0 | ~last_id);
        g2b_bit    = prev_bit ^ operand[bit_idx];
        work_next  = work;
        work_next[bit_idx] = g2b_bit;
        conv_value = cur_dir ? work_next : (operand ^ (operand >> 1));
        conv_last  = ~cur_dir | (bit_idx == '0);
    end

    assign busy = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            last_id <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
`ifdef GRAY_CONV_STATS_EN
            conv_count <= 8'd0;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (conv_last) begin
                        result  <= conv_value;
                        done    <= 1'b1;
                        done_id <= cur_id;
`ifdef GRAY_CONV_STATS_EN
                        conv_count <= conv_count + 8'd1;
`endif
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_id <= cur_id;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: operand and bit-serial working registers carry no reset; they are always loaded at capture before use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && any_req) begin
            cur_id   <= pick1;
            cur_dir  <= pick1 ? dir1 : dir0;
            operand  <= pick1 ? data1 : data0;
            work     <= '0;
            prev_bit <= 1'b0;
            bit_idx  <= CW'(WIDTH - 1);
        end else if (state == S_CONV && cur_dir) begin
            work     <= work_next;
            prev_bit <= g2b_bit;
            bit_idx  <= bit_idx - CW'(1);
        end
    end

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Scoreboard bench for gray_conv_scheduler (WIDTH=4); covers GRAY_CONV_STATS_EN when defined.
module tb_gray_conv_scheduler;

    localparam int W = 4;

    typedef struct packed {
        logic         id;
        logic [W-1:0] val;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic         dir0 = 1'b0, dir1 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, busy, done, done_id;
    logic [W-1:0] result;
`ifdef GRAY_CONV_STATS_EN
    logic [7:0]   conv_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    sb_t sb[$];
    logic [W-1:0] hold_exp = '0;
    logic prev_gnt0 = 1'b0, prev_gnt1 = 1'b0;

    gray_conv_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .result(result)
`ifdef GRAY_CONV_STATS_EN
        , .conv_count(conv_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Output monitor: scoreboard pops on done, result-hold and grant-pulse checks otherwise.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_exp  = '0;
            prev_gnt0 = 1'b0;
            prev_gnt1 = 1'b0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("done_id", 32'(done_id), 32'(e.id));
                    check("result", 32'(result), 32'(e.val));
                    hold_exp = e.val;
                end
            end else begin
                check("result_hold", 32'(result), 32'(hold_exp));
            end
            if (gnt0 || gnt1) check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
            if (gnt0) check("gnt0_pulse", 32'(prev_gnt0), 32'd0);
            if (gnt1) check("gnt1_pulse", 32'(prev_gnt1), 32'd0);
            prev_gnt0 = gnt0;
            prev_gnt1 = gnt1;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_one(input logic id, input logic dir, input logic [W-1:0] data,
                           input logic [W-1:0] exp, output logic [W-1:0] got);
        int n;
        bit seen;
        int exp_lat;
        exp_lat = dir ? W : 1;
        got = '0;
        sb.push_back('{id: id, val: exp});
        @(posedge clk); #1;
        if (id) begin req1 = 1'b1; dir1 = dir; data1 = data; end
        else    begin req0 = 1'b1; dir0 = dir; data0 = data; end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (id ? gnt1 : gnt0) begin seen = 1; break; end
        end
        check("gnt_seen", 32'(seen), 32'd1);
        check("busy_at_gnt", 32'(busy), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        // Disturb operands after capture; the conversion must not notice.
        data0 = ~data0; data1 = ~data1; dir0 = ~dir0; dir1 = ~dir1;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) break;
            check("busy_conv", 32'(busy), 32'd1);
        end
        check("latency", 32'(n), 32'(exp_lat));
        got = result;
        check("busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] got, g;
        int dones, gnts;
        logic order[$];
        bit seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_result", 32'(result), 32'd0);

        // Directed cases from the test plan, expected values as constants.
        run_one(1'b0, 1'b0, 4'b0101, 4'b0111, got);
        run_one(1'b1, 1'b1, 4'b1111, 4'b1010, got);

        // Simultaneous requests held high: service order 0,1,0,1.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{id: 1'b0, val: to_gray(4'b0011)});
            sb.push_back('{id: 1'b1, val: from_gray(4'b0110)});
        end
        @(posedge clk); #1;
        req0 = 1'b1; dir0 = 1'b0; data0 = 4'b0011;
        req1 = 1'b1; dir1 = 1'b1; data1 = 4'b0110;
        dones = 0; gnts = 0;
        for (int k = 0; k < 60 && dones < 4; k++) begin
            @(negedge clk);
            if (gnt0) begin gnts++; order.push_back(1'b0); end
            if (gnt1) begin gnts++; order.push_back(1'b1); end
            if (done) dones++;
        end
        @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (gnt0 || gnt1) gnts++;
        end
        check("tie_dones", 32'(dones), 32'd4);
        check("tie_gnts", 32'(gnts), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            check("tie_order", 32'(order[i]), 32'(i % 2));

        // Reset during the third CONV cycle of a Gray->binary conversion.
        sb.push_back('{id: 1'b1, val: 4'b1010});
        @(posedge clk); #1;
        req1 = 1'b1; dir1 = 1'b1; data1 = 4'b1111;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (gnt1) begin seen = 1; break; end
        end
        check("abort_gnt", 32'(seen), 32'd1);
        @(posedge clk); #1 req1 = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_gnt1", 32'(gnt1), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_one(1'b0, 1'b1, 4'b1001, 4'b1110, got);

        // Round trip sweep: DUT Gray output fed back as a Gray->binary request.
        for (int v = 0; v < 16; v++) begin
            run_one(1'b0, 1'b0, W'(v), to_gray(W'(v)), g);
            run_one(1'b1, 1'b1, g, W'(v), got);
            check("round_trip", 32'(got), 32'(v));
        end

`ifdef GRAY_CONV_STATS_EN
        do_reset();
        @(negedge clk);
        check("cnt_rst", 32'(conv_count), 32'd0);
        for (int i = 1; i <= 257; i++) begin
            run_one(i[0], 1'b0, W'(i), to_gray(W'(i)), got);
            if (i == 255) check("cnt_255", 32'(conv_count), 32'd255);
            if (i == 256) check("cnt_wrap", 32'(conv_count), 32'd0);
            if (i == 257) check("cnt_257", 32'(conv_count), 32'd1);
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
